score_vec_packer: RTL and testbench

//   Collects the N class scores streamed one per beat from the final FC layer and packs them

---
 rtl/score_vec_packer.sv | 147 ++++++++++++++
 tb/tb_score_vec_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_vec_packer.sv
// score_vec_packer
// Gathers N scores streamed one per beat from the last FC layer into one flat
// N*WIDTH vector for argmax. Score k lands at bits [k*WIDTH +: WIDTH].
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. A source keeps valid and its payload stable
// until that edge. The packer's ready/valid outputs come only from registered
// state (and rst for s_ready), never from the other side's inputs.
//
// Frame-length errors are reported on m_err alongside the vector:
//   - s_last before N beats: short frame, unfilled slots read as zero.
//   - N beats without s_last: long frame, the vector goes out with the first
//     N scores and the rest of the frame (through its s_last) is dropped.
module score_vec_packer #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N*WIDTH-1:0]   m_vec,
  output logic                 m_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // COLLECT: filling slots; HOLD: presenting the vector; DRAIN: dropping the
  // tail of an over-long frame.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [N*WIDTH-1:0]   buffer;
  logic [N*WIDTH-1:0]   buf_wr;
  logic                 drain;
  logic                 beat;
  logic                 at_end;
  logic                 frame_done;
  logic                 out_hs;

  // Handshake qualifiers; only registered state (plus rst) drives the readies/valids.
  always_comb begin
    s_ready    = !rst && ((state == ST_COLLECT) || (state == ST_DRAIN));
    m_valid    = (state == ST_HOLD);
    beat       = s_valid && s_ready;
    out_hs     = m_valid && m_ready;
    at_end     = (cnt == CW'(N - 1));
    frame_done = (state == ST_COLLECT) && beat && (s_last || at_end);
  end

  // Buffer image with the incoming score written into slot cnt.
  always_comb begin
    buf_wr = buffer;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        buf_wr[k*WIDTH +: WIDTH] = s_data;
      end
    end
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: begin
        if (frame_done) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_hs) begin
          state_nxt = drain ? ST_DRAIN : ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (beat && s_last) begin
          state_nxt = ST_COLLECT;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot counter, collection buffer, output vector/error and drain flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      buffer <= '0;
      m_vec  <= '0;
      m_err  <= 1'b0;
      drain  <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (beat) begin
            buffer <= buf_wr;
            if (s_last || at_end) begin
              // Vector is registered so it appears with m_valid next cycle.
              m_vec <= buf_wr;
              m_err <= !(s_last && at_end);
              drain <= at_end && !s_last;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_hs) begin
            // Clearing here gives short frames their zero-filled tail slots.
            buffer <= '0;
            m_vec  <= '0;
            m_err  <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_DRAIN: begin
          if (beat && s_last) begin
            drain <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_vec_packer.sv
// Testbench for score_vec_packer: directed scenarios then randomized frames,
// checked by a scoreboard fed from a frame-level reference model.
module tb_score_vec_packer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int VW = N*W + 1;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [N*W-1:0]   m_vec;
  logic             m_err;

  logic             m_ready_dir;
  logic             m_ready_rnd;
  bit               rand_mode;

  int               n_chk;
  int               n_fail;

  logic [VW-1:0]    exp_q[$];
  logic [W-1:0]     fq[$];
  logic [W-1:0]     pend[$];
  bit               dropping;
  bit               emit_pending;
  bit               mon_en;
  bit               cnt_en;
  int               bubbles;
  bit               hs_prev;
  bit               held;
  logic [VW-1:0]    held_val;

  score_vec_packer #(.N(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_vec   (m_vec),
    .m_err   (m_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_ready = rand_mode ? m_ready_rnd : m_ready_dir;

  always @(posedge clk) begin
    #1;
    m_ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the sequence of accepted beats: scores accumulate into a frame;
  // a frame closes on s_last or on its N-th score. A frame closed by count
  // alone is flagged and the stream is skipped up to and including s_last.
  task automatic model_beat(input logic [W-1:0] d, input bit last);
    logic [N*W-1:0] v;
    int             len;
    if (dropping) begin
      if (last) dropping = 1'b0;
      return;
    end
    pend.push_back(d);
    len = pend.size();
    if (last || len == N) begin
      v = '0;
      for (int k = 0; k < len; k++) v[k*W +: W] = pend[k];
      exp_q.push_back({!(last && len == N), v});
      if (!last) dropping = 1'b1;
      pend.delete();
      emit_pending = 1'b1;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    dropping = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat and hold it until accepted; leaves s_valid high.
  task automatic send_beat(input logic [W-1:0] d, input bit last);
    bit rdy;
    int budget;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 500) begin
        check("beat_accept_timeout", VW'(0), VW'(1));
        s_valid = 1'b0;
        return;
      end
    end
    model_beat(d, last);
  endtask

  task automatic send_seq(input bit with_last);
    int n;
    n = fq.size();
    for (int i = 0; i < n; i++) begin
      send_beat(fq[i], with_last && (i == n - 1));
    end
  endtask

  task automatic idle(input int cycles);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (mon_en) begin
      if (rst) check("s_ready_in_reset", VW'(s_ready), VW'(0));
      if (emit_pending) begin
        check("m_valid_latency", VW'(m_valid), VW'(1));
        emit_pending = 1'b0;
      end
      if (hs_prev) begin
        check("m_valid_drop", VW'(m_valid), VW'(0));
        check("m_vec_cleared", VW'(m_vec), VW'(0));
        hs_prev = 1'b0;
      end
      if (cnt_en && !s_ready) bubbles++;
      if (m_valid === 1'b1) begin
        check("s_ready_in_hold", VW'(s_ready), VW'(0));
        if (held) check("hold_stable", {m_err, m_vec}, held_val);
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_vector", {m_err, m_vec}, VW'(0));
            if ({m_err, m_vec} == VW'(0)) begin
              n_fail++;
              $display("FAIL unexpected_vector: got zero vector, none expected");
            end
          end else begin
            e = exp_q.pop_front();
            check("vector", {m_err, m_vec}, e);
          end
          hs_prev = 1'b1;
          held    = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = {m_err, m_vec};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int frames;
    int wait_cnt;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready_dir = 1'b1; rand_mode = 1'b0;
    n_chk = 0; n_fail = 0; bubbles = 0;
    dropping = 1'b0; emit_pending = 1'b0; mon_en = 1'b0; cnt_en = 1'b0;
    hs_prev = 1'b0; held = 1'b0; held_val = '0;

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid", VW'(m_valid), VW'(0));
    check("reset_m_vec",   VW'(m_vec),   VW'(0));
    check("reset_m_err",   VW'(m_err),   VW'(0));
    check("idle_s_ready",  VW'(s_ready), VW'(1));
    @(posedge clk);
    #1;

    // 1: full frame, consumer always ready
    fq = '{16'd7, 16'd5, 16'd20, 16'd10};
    send_seq(1'b1);
    idle(3);

    // 2: same frame, consumer stalls 5 cycles
    m_ready_dir = 1'b0;
    send_seq(1'b1);
    s_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    m_ready_dir = 1'b1;
    idle(3);

    // 3: short frame
    fq = '{16'd30, 16'd25};
    send_seq(1'b1);
    idle(3);

    // 4: long frame, drained tail, then a clean frame
    fq = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_seq(1'b0);
    fq = '{16'd9, 16'd9};
    send_seq(1'b1);
    fq = '{16'd5, 16'd6, 16'd7, 16'd8};
    send_seq(1'b1);
    idle(3);

    // 5: reset mid-frame discards the partial frame
    fq = '{16'd11, 16'd12};
    send_seq(1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    fq = '{16'd1, 16'd50, 16'd25, 16'd30};
    send_seq(1'b1);
    idle(3);

    // 6: back-to-back frames, one bubble each
    frames  = 5;
    bubbles = 0;
    cnt_en  = 1'b1;
    for (int f = 0; f < frames; f++) begin
      fq.delete();
      for (int i = 0; i < N; i++) fq.push_back(W'($urandom));
      send_seq(1'b1);
    end
    s_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    cnt_en = 1'b0;
    check("bubbles_per_frame", VW'(bubbles), VW'(frames));
    idle(3);

    // randomized frames, lengths, gaps and consumer stalls
    rand_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      fq.delete();
      for (int i = 0; i < $urandom_range(1, N + 2); i++) fq.push_back(W'($urandom));
      send_seq($urandom_range(0, 7) != 0);
      idle($urandom_range(0, 2));
    end
    fq = '{16'h1111, 16'h2222};
    send_seq(1'b1);
    idle(1);
    rand_mode   = 1'b0;
    m_ready_dir = 1'b1;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    check("scoreboard_drained", VW'(exp_q.size()), VW'(0));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
